uart_tx_arb: RTL and testbench

- Shares one 8N1 UART transmitter between NUM_REQ byte producers, e.g. a status reporter, a debug dumper and a loopback echo.
- Each requester presents a byte with a level request and gets a one-cycle acknowledge when its byte is taken.
- The arbiter grants round-robin, issues one tx_trig pulse plus data to the transmitter, then holds off the next grant for a full frame time.
- Sits between the producers and the transmitter in the uart_tx top level.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_arb_if.sv | 24 ++
 rtl/rr_pick.sv | 45 ++++
 rtl/uart_tx_arb.sv | 130 +++++++++++++
 tb/tb_uart_tx_arb.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the UART transmit arbiter.
// Pure declarations: no logic, no latency, no flow control.
package uart_pkg;

    localparam int BAUD_END_DEF = 5207;
    localparam int BAUD_END_SIM = 56;
    localparam int FRAME_BITS   = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRIG = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Producer-side request/ack bundle and transmitter-side trigger/data for uart_tx_arb.
// Level requests in, one-cycle acks out; ack is the only backpressure a producer sees.
interface uart_tx_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ack;
    logic                 tx_trig;
    logic [7:0]           uart_tx;
    logic                 busy;
    logic [IDW-1:0]       grant_id;

    modport master (
        output req, req_data,
        input  req_ack, tx_trig, uart_tx, busy, grant_id
    );

    modport slave (
        input  req, req_data,
        output req_ack, tx_trig, uart_tx, busy, grant_id
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin winner select starting at rr_ptr_i; zero latency.
// UART_TX_ARB_PRIO_EN: requester 0 always wins when requesting, others rotate.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     rr_ptr_i,
    output logic               any_req_o,
    output logic [IDW-1:0]     winner_o
);

    logic [NUM_REQ-1:0] scan_req;
    logic               hi_found;
    logic [IDW-1:0]     hi_idx;
    logic [IDW-1:0]     lo_idx;

    always_comb begin
        scan_req = req_i;
`ifdef UART_TX_ARB_PRIO_EN
        scan_req[0] = 1'b0;
`endif
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        // Descending scan: the last hit is the lowest index, both overall and at/above rr_ptr.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (scan_req[i]) begin
                lo_idx = IDW'(i);
                if (i >= int'(rr_ptr_i)) begin
                    hi_idx   = IDW'(i);
                    hi_found = 1'b1;
                end
            end
        end
        any_req_o = |req_i;
        winner_o  = hi_found ? hi_idx : lo_idx;
`ifdef UART_TX_ARB_PRIO_EN
        if (req_i[0]) begin
            winner_o = '0;
        end
`endif
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one 8N1 transmitter: capture->tx_trig 1 clk, then FRAME_CYC hold-off.
// Producers wait with req held until ack; build with UART_TX_ARB_PRIO_EN for requester-0 priority.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BAUD_END  = BAUD_END_DEF,
    parameter int FRAME_CYC = (BAUD_END + 1) * FRAME_BITS,
    parameter int IDW       = $clog2(NUM_REQ)
) (
    input  logic         sclk,
    input  logic         s_rst,
    uart_tx_arb_if.slave bus
);

    localparam int FC_W = $clog2(FRAME_CYC);

    arb_state_e         state_q,     state_d;
    logic [NUM_REQ-1:0] req_ack_q,   req_ack_d;
    logic               tx_trig_q,   tx_trig_d;
    logic [7:0]         uart_tx_q,   uart_tx_d;
    logic               busy_q,      busy_d;
    logic [IDW-1:0]     grant_id_q,  grant_id_d;
    logic [IDW-1:0]     rr_ptr_q,    rr_ptr_d;
    logic [FC_W-1:0]    frame_cnt_q, frame_cnt_d;

    logic               any_req;
    logic [IDW-1:0]     winner;
    logic [7:0]         win_byte;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req_i     (bus.req),
        .rr_ptr_i  (rr_ptr_q),
        .any_req_o (any_req),
        .winner_o  (winner)
    );

    always_comb begin
        win_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IDW'(i)) begin
                win_byte = bus.req_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state_q     <= IDLE;
            req_ack_q   <= '0;
            tx_trig_q   <= 1'b0;
            uart_tx_q   <= '0;
            busy_q      <= 1'b0;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            req_ack_q   <= req_ack_d;
            tx_trig_q   <= tx_trig_d;
            uart_tx_q   <= uart_tx_d;
            busy_q      <= busy_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ack_d   = '0;
        tx_trig_d   = 1'b0;
        uart_tx_d   = uart_tx_q;
        busy_d      = busy_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    uart_tx_d         = win_byte;
                    req_ack_d[winner] = 1'b1;
                    grant_id_d        = winner;
                    busy_d            = 1'b1;
                    state_d           = TRIG;
                end
            end
            TRIG: begin
                // Outputs are registered, so the trigger pulse lands one clock after the ack.
                tx_trig_d   = 1'b1;
                frame_cnt_d = '0;
                state_d     = WAIT;
`ifdef UART_TX_ARB_PRIO_EN
                if (grant_id_q == IDW'(NUM_REQ - 1)) begin
                    rr_ptr_d = IDW'(1);
                end else if (grant_id_q != '0) begin
                    rr_ptr_d = grant_id_q + 1'b1;
                end
`else
                if (grant_id_q == IDW'(NUM_REQ - 1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = grant_id_q + 1'b1;
                end
`endif
            end
            WAIT: begin
                if (frame_cnt_q == FC_W'(FRAME_CYC - 1)) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req_ack  = req_ack_q;
    assign bus.tx_trig  = tx_trig_q;
    assign bus.uart_tx  = uart_tx_q;
    assign bus.busy     = busy_q;
    assign bus.grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb (NUM_REQ=4, BAUD_END=1, FRAME_CYC=20), default round-robin build.
// Grants are predicted into a queue when requests are driven and popped at each tx_trig.
module tb_uart_tx_arb;

    localparam int NUM_REQ   = 4;
    localparam int FRAME_CYC = 20;

    typedef struct {
        logic [NUM_REQ-1:0] req;
        logic [31:0]        data;
        logic [NUM_REQ-1:0] exp_ack;
        logic [1:0]         exp_id;
        logic [7:0]         exp_byte;
    } vec_t;

    typedef struct {
        logic [1:0] id;
        logic [7:0] byte_v;
    } sb_t;

    logic sclk = 1'b0;
    logic s_rst;
    int   checks = 0;
    int   errors = 0;
    sb_t  sb_q[$];
    vec_t vecs[9];

    int                 mon_cyc = 0;
    int                 last_trig = 0;
    bit                 have_last = 1'b0;
    logic [NUM_REQ-1:0] prev_ack = '0;

    uart_tx_arb_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_arb #(
        .NUM_REQ   (NUM_REQ),
        .BAUD_END  (1),
        .FRAME_CYC (FRAME_CYC)
    ) dut (
        .sclk  (sclk),
        .s_rst (s_rst),
        .bus   (bus)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic push(input logic [1:0] id, input logic [7:0] b);
        sb_t e;
        e.id     = id;
        e.byte_v = b;
        sb_q.push_back(e);
    endtask

    // Ticks until an ack appears; n counts ticks, continuing from n0.
    task automatic wait_ack(input int n0, output logic [NUM_REQ-1:0] ack, output int n);
        n = n0;
        do begin
            tick();
            n++;
        end while (bus.req_ack == '0 && n < 100);
        ack = bus.req_ack;
    endtask

    task automatic wait_busy_low(input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.busy && n < 200);
        chk(name, 32'(n), 32'(FRAME_CYC + 1));
    endtask

    // Scoreboard and timing monitor on every trigger pulse.
    initial begin
        forever begin
            @(posedge sclk);
            #2;
            mon_cyc++;
            if (s_rst) begin
                have_last = 1'b0;
            end else if (bus.tx_trig) begin
                chk("trig_after_ack", 32'(prev_ack != '0), 32'd1);
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    chk("trig_grant_id", 32'(bus.grant_id), 32'(e.id));
                    chk("trig_uart_tx", 32'(bus.uart_tx), 32'(e.byte_v));
                end
                if (have_last) begin
                    chk("trig_spacing_min", 32'(mon_cyc - last_trig >= FRAME_CYC + 2), 32'd1);
                end
                last_trig = mon_cyc;
                have_last = 1'b1;
            end
            prev_ack = bus.req_ack;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_REQ-1:0] ack;
        int                 n;
        logic [1:0]         rr_ids[5];

        vecs[0] = '{4'b0100, 32'h44A52211, 4'b0100, 2'd2, 8'hA5};
        vecs[1] = '{4'b0011, 32'h01020304, 4'b0001, 2'd0, 8'h04};
        vecs[2] = '{4'b0011, 32'h0A0B0C0D, 4'b0010, 2'd1, 8'h0C};
        vecs[3] = '{4'b1001, 32'hF0E1D2C3, 4'b1000, 2'd3, 8'hF0};
        vecs[4] = '{4'b1010, 32'h55667788, 4'b0010, 2'd1, 8'h77};
        vecs[5] = '{4'b0001, 32'h000000FF, 4'b0001, 2'd0, 8'hFF};
        vecs[6] = '{4'b1110, 32'h9ABCDEF0, 4'b0010, 2'd1, 8'hDE};
        vecs[7] = '{4'b0101, 32'h13579BDF, 4'b0100, 2'd2, 8'h57};
        vecs[8] = '{4'b1000, 32'h80402010, 4'b1000, 2'd3, 8'h80};
        rr_ids  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // Reset held with every requester active: nothing may leak out.
        s_rst        = 1'b1;
        bus.req      = 4'b1111;
        bus.req_data = 32'h13121110;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_req_ack", 32'(bus.req_ack), 32'd0);
            chk("rst_tx_trig", 32'(bus.tx_trig), 32'd0);
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_uart_tx", 32'(bus.uart_tx), 32'h00);
            chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
        end

        // Continuous requests from all four: strict rotation, one frame apart.
        for (int g = 0; g < 5; g++) begin
            push(rr_ids[g], 8'h10 + 8'(rr_ids[g]));
        end
        s_rst = 1'b0;
        wait_ack(0, ack, n);
        chk("rr_first_lat", 32'(n), 32'd1);
        chk("rr_ack_0", 32'(ack), 32'd1);
        for (int g = 1; g < 5; g++) begin
            tick();
            chk("rr_ack_single", 32'(bus.req_ack), 32'd0);
            wait_ack(1, ack, n);
            chk("rr_ack_spacing", 32'(n), 32'(FRAME_CYC + 2));
            chk("rr_ack_order", 32'(ack), 32'(4'b0001 << rr_ids[g]));
        end
        bus.req = '0;
        wait_busy_low("rr_busy_len");

        // Single-capture vectors, including the rr_ptr wrap from 3 back to 0.
        for (int v = 0; v < 9; v++) begin
            bus.req      = vecs[v].req;
            bus.req_data = vecs[v].data;
            push(vecs[v].exp_id, vecs[v].exp_byte);
            wait_ack(0, ack, n);
            chk("vec_ack_lat", 32'(n), 32'd1);
            chk("vec_ack", 32'(ack), 32'(vecs[v].exp_ack));
            bus.req = '0;
            wait_busy_low("vec_busy_len");
        end

        // Reset five cycles after the trigger, mid-frame.
        bus.req      = 4'b1000;
        bus.req_data = 32'hC0FFEE42;
        push(2'd3, 8'hC0);
        wait_ack(0, ack, n);
        chk("mid_ack", 32'(ack), 32'b1000);
        bus.req = '0;
        tick();
        chk("mid_trig", 32'(bus.tx_trig), 32'd1);
        for (int c = 0; c < 5; c++) begin
            tick();
        end
        s_rst = 1'b1;
        tick();
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_uart_tx", 32'(bus.uart_tx), 32'd0);
        chk("mid_rst_grant_id", 32'(bus.grant_id), 32'd0);
        s_rst        = 1'b0;
        bus.req      = 4'b0010;
        bus.req_data = 32'h00003C00;
        push(2'd1, 8'h3C);
        wait_ack(0, ack, n);
        chk("post_rst_lat", 32'(n), 32'd1);
        chk("post_rst_ack", 32'(ack), 32'b0010);
        bus.req = '0;
        wait_busy_low("post_rst_busy_len");

        tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
